// File: rtl/decode_stage.sv
// RV32 decode stage: combinational field/immediate decode of the fetched word,
// registered into a 1- or 2-entry in-order output buffer with flush.
//
// state | meaning
// EMPTY | no buffered entry, out_valid low
// ONE   | head entry valid in e0_q
// TWO   | head in e0_q, second entry in e1_q (DEPTH=2 only)
module decode_stage #(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 2,
  parameter int ZERO_UNUSED_RS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic            out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imme,
  output logic [XLEN-1:0] out_pc,
  output logic            out_ecall,
  output logic            out_ebreak,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imme;
    logic [XLEN-1:0] pc;
    logic            ecall;
    logic            ebreak;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state_q, state_d;
  entry_t             e0_q, e0_d, e1_q, e1_d;
  entry_t             dec;
  logic signed [31:0] imm32;
  logic               no_rs1, no_rs2;
  logic               has_room, push, pop;

  always_comb begin
    dec         = '0;
    imm32       = '0;
    no_rs1      = 1'b0;
    no_rs2      = 1'b0;
    dec.opcode  = in_instr[6:0];
    dec.func3   = in_instr[14:12];
    dec.func7   = in_instr[30];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.pc      = in_pc;
    dec.ecall   = (in_instr == 32'h00000073);
    dec.ebreak  = (in_instr == 32'h00100073);
    unique case (in_instr[6:0])
      OP_LUI, OP_AUIPC: begin
        imm32  = {in_instr[31:12], 12'b0};
        no_rs1 = 1'b1;
        no_rs2 = 1'b1;
      end
      OP_JAL: begin
        imm32  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        no_rs1 = 1'b1;
        no_rs2 = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM: begin
        imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
        no_rs2 = 1'b1;
      end
      OP_BRANCH: imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      OP_STORE:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      OP_OP:     imm32 = '0;
      default:   dec.illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) dec.illegal = 1'b1;
    if (ZERO_UNUSED_RS != 0 && no_rs1) dec.rs1 = '0;
    if (ZERO_UNUSED_RS != 0 && no_rs2) dec.rs2 = '0;
    // signed cast widens by replicating instr[31]
    dec.imme = XLEN'(imm32);
  end

  assign has_room  = (DEPTH == 1) ? (state_q == EMPTY) : (state_q != TWO);
  assign in_ready  = !rst && (flush || has_room || out_ready);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (push) begin
          e0_d    = dec;
          state_d = ONE;
        end
        ONE: begin
          if (push && pop) begin
            e0_d = dec;
          end else if (push) begin
            e1_d    = dec;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (push && pop) begin
            e0_d = e1_q;
            e1_d = dec;
          end else if (pop) begin
            e0_d    = e1_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign out_opcode  = e0_q.opcode;
  assign out_func3   = e0_q.func3;
  assign out_func7   = e0_q.func7;
  assign out_rs1     = e0_q.rs1;
  assign out_rs2     = e0_q.rs2;
  assign out_rd      = e0_q.rd;
  assign out_imme    = e0_q.imme;
  assign out_pc      = e0_q.pc;
  assign out_ecall   = e0_q.ecall;
  assign out_ebreak  = e0_q.ebreak;
  assign out_illegal = e0_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a default (XLEN=32) instance and an XLEN=64
// instance share stimulus; expectations are hand-computed encodings.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [63:0] in_pc64;

  logic        a_in_ready, a_out_valid, a_func7, a_ecall, a_ebreak, a_illegal;
  logic [6:0]  a_opcode;
  logic [2:0]  a_func3;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [31:0] a_imme, a_pc;

  logic        b_in_ready, b_out_valid, b_func7, b_ecall, b_ebreak, b_illegal;
  logic [6:0]  b_opcode;
  logic [2:0]  b_func3;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [63:0] b_imme, b_pc;

  int n_cmp = 0;
  int n_err = 0;

  assign in_pc64 = {32'h0, in_pc};

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_opcode(a_opcode), .out_func3(a_func3), .out_func7(a_func7), .out_rs1(a_rs1),
    .out_rs2(a_rs2), .out_rd(a_rd), .out_imme(a_imme), .out_pc(a_pc),
    .out_ecall(a_ecall), .out_ebreak(a_ebreak), .out_illegal(a_illegal)
  );

  decode_stage #(.XLEN(64), .DEPTH(2), .ZERO_UNUSED_RS(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_opcode(b_opcode), .out_func3(b_func3), .out_func7(b_func7), .out_rs1(b_rs1),
    .out_rs2(b_rs2), .out_rd(b_rd), .out_imme(b_imme), .out_pc(b_pc),
    .out_ecall(b_ecall), .out_ebreak(b_ebreak), .out_illegal(b_illegal)
  );

  // decode vectors: instr, imm (32-bit), rs1, rs2, rd, func7, {ecall,ebreak,illegal}
  localparam int NV = 11;
  logic [31:0] v_instr [NV] = '{32'hFFF00093, 32'h800000EF, 32'hABCDE2B7, 32'hFE208EE3,
                                32'h0020A423, 32'h402081B3, 32'h00000073, 32'h00100073,
                                32'h0000007F, 32'h00000000, 32'hFF812203};
  logic [31:0] v_imm   [NV] = '{32'hFFFFFFFF, 32'hFFF00000, 32'hABCDE000, 32'hFFFFFFFC,
                                32'h00000008, 32'h00000000, 32'h00000000, 32'h00000001,
                                32'h00000000, 32'h00000000, 32'hFFFFFFF8};
  logic [4:0]  v_rs1   [NV] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2};
  logic [4:0]  v_rs2   [NV] = '{5'd0, 5'd0, 5'd0, 5'd2, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [4:0]  v_rd    [NV] = '{5'd1, 5'd1, 5'd5, 5'd29, 5'd8, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4};
  logic        v_f7    [NV] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0]  v_flags [NV] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b100, 3'b010, 3'b001, 3'b001, 3'b000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'hFFF00093; in_pc = 32'h40;
    tick();
    tick();
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", a_in_ready); end
    n_cmp++; if (a_imme !== 32'h0) begin n_err++; $display("FAIL rst_imme: got %h expected 0", a_imme); end
    n_cmp++; if (a_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h expected 0", a_pc); end
    n_cmp++; if ({a_opcode, a_rd, a_rs1, a_rs2} !== 22'h0) begin n_err++; $display("FAIL rst_fields: got %h expected 0", {a_opcode, a_rd, a_rs1, a_rs2}); end
    n_cmp++; if (b_imme !== 64'h0) begin n_err++; $display("FAIL rst_imme64: got %h expected 0", b_imme); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b expected 1", a_in_ready); end
    tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_empty: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_decode();
    logic [31:0] exp_pc;
    for (int i = 0; i < NV; i++) begin
      exp_pc    = 32'h200 + 32'(i * 4);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = v_instr[i];
      in_pc     = exp_pc;
      #1;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL dec%0d_no_bypass: got %b expected 0", i, a_out_valid); end
      tick();
      in_valid = 1'b0;
      #1;
      n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL dec%0d_valid: got %b expected 1", i, a_out_valid); end
      n_cmp++; if (a_opcode !== v_instr[i][6:0]) begin n_err++; $display("FAIL dec%0d_opcode: got %h expected %h", i, a_opcode, v_instr[i][6:0]); end
      n_cmp++; if (a_func3 !== v_instr[i][14:12]) begin n_err++; $display("FAIL dec%0d_func3: got %h expected %h", i, a_func3, v_instr[i][14:12]); end
      n_cmp++; if (a_func7 !== v_f7[i]) begin n_err++; $display("FAIL dec%0d_func7: got %b expected %b", i, a_func7, v_f7[i]); end
      n_cmp++; if (a_rs1 !== v_rs1[i]) begin n_err++; $display("FAIL dec%0d_rs1: got %0d expected %0d", i, a_rs1, v_rs1[i]); end
      n_cmp++; if (a_rs2 !== v_rs2[i]) begin n_err++; $display("FAIL dec%0d_rs2: got %0d expected %0d", i, a_rs2, v_rs2[i]); end
      n_cmp++; if (a_rd !== v_rd[i]) begin n_err++; $display("FAIL dec%0d_rd: got %0d expected %0d", i, a_rd, v_rd[i]); end
      n_cmp++; if (a_pc !== exp_pc) begin n_err++; $display("FAIL dec%0d_pc: got %h expected %h", i, a_pc, exp_pc); end
      n_cmp++; if ({a_ecall, a_ebreak, a_illegal} !== v_flags[i]) begin n_err++; $display("FAIL dec%0d_flags: got %b expected %b", i, {a_ecall, a_ebreak, a_illegal}, v_flags[i]); end
      if (v_flags[i][0] == 1'b0) begin
        n_cmp++; if (a_imme !== v_imm[i]) begin n_err++; $display("FAIL dec%0d_imme: got %h expected %h", i, a_imme, v_imm[i]); end
        n_cmp++; if (b_imme !== {{32{v_imm[i][31]}}, v_imm[i]}) begin n_err++; $display("FAIL dec%0d_imme64: got %h expected %h", i, b_imme, {{32{v_imm[i][31]}}, v_imm[i]}); end
        n_cmp++; if (b_rs1 !== v_rs1[i] || b_rs2 !== v_rs2[i]) begin n_err++; $display("FAIL dec%0d_rs64: got %0d/%0d expected %0d/%0d", i, b_rs1, b_rs2, v_rs1[i], v_rs2[i]); end
      end
      tick();
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL dec%0d_popped: got %b expected 0", i, a_out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100093; in_pc = 32'h300;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy_empty: got %b expected 1", a_in_ready); end
    tick();
    in_instr = 32'h00200113; in_pc = 32'h304;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy_one: got %b expected 1", a_in_ready); end
    n_cmp++; if (a_pc !== 32'h300) begin n_err++; $display("FAIL b2b_head_one: got %h expected 300", a_pc); end
    tick();
    in_instr = 32'h00300193; in_pc = 32'h308;
    #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_full: got %b expected 0", a_in_ready); end
    n_cmp++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_full64: got %b expected 0", b_in_ready); end
    tick();
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_hold: got %b expected 0", a_in_ready); end
    n_cmp++; if (a_pc !== 32'h300 || a_rd !== 5'd1 || a_imme !== 32'h1) begin n_err++; $display("FAIL b2b_head_stable: got pc %h rd %0d imm %h expected 300/1/1", a_pc, a_rd, a_imme); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy_release: got %b expected 1", a_in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b1 || a_pc !== 32'h304 || a_rd !== 5'd2) begin n_err++; $display("FAIL b2b_second: got v %b pc %h rd %0d expected 1/304/2", a_out_valid, a_pc, a_rd); end
    tick();
    n_cmp++; if (a_out_valid !== 1'b1 || a_pc !== 32'h308 || a_rd !== 5'd3) begin n_err++; $display("FAIL b2b_third: got v %b pc %h rd %0d expected 1/308/3", a_out_valid, a_pc, a_rd); end
    n_cmp++; if (b_pc !== 64'h308) begin n_err++; $display("FAIL b2b_third64: got %h expected 308", b_pc); end
    tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100093; in_pc = 32'h500;
    tick();
    in_instr = 32'h00200113; in_pc = 32'h504;
    tick();
    flush = 1'b1;
    in_instr = 32'h00300193; in_pc = 32'h508;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b expected 1", a_in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b expected 0", a_out_valid); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped: got %b expected 0", a_out_valid); end
    in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 32'h50C;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b1 || a_pc !== 32'h50C || a_rd !== 5'd4) begin n_err++; $display("FAIL flush_restart: got v %b pc %h rd %0d expected 1/50c/4", a_out_valid, a_pc, a_rd); end
    tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_restart_pop: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100093; in_pc = 32'h600;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_loaded: got %b expected 1", a_out_valid); end
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    in_instr = 32'h00200113; in_pc = 32'h604;
    #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_ready: got %b expected 0", a_in_ready); end
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_empty: got %b expected 0", a_out_valid); end
    n_cmp++; if (a_pc !== 32'h0 || a_rd !== 5'd0) begin n_err++; $display("FAIL rmid_cleared: got pc %h rd %0d expected 0/0", a_pc, a_rd); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready_after: got %b expected 1", a_in_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
